// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFinish
    } state_e;

    state_e state_q, state_d;

    logic            start_q;
    logic            sel_rem_q, sel_rem_d;
    logic            neg_res_q, neg_res_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    logic            launch;
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_val;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] fin_sel;
    logic [XLEN-1:0] fin_val;

    assign launch    = start & ~start_q & (state_q == StIdle);
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[XLEN-1];
    assign b_neg     = is_signed & divisor[XLEN-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign overflow  = is_signed & (dividend == {1'b1, {(XLEN - 1){1'b0}}}) & (divisor == '1);

    // Divide-by-zero takes precedence; overflow only applies with divisor == -1.
    assign special_val = div_zero ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);

    // Restoring step: trial[XLEN] set means the subtraction went negative.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    assign fin_sel = sel_rem_q ? rem_q : quo_q;
    assign fin_val = neg_res_q ? -fin_sel : fin_sel;

    always_comb begin
        state_d   = state_q;
        sel_rem_d = sel_rem_q;
        neg_res_d = neg_res_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (launch) begin
                    rem_d = '0;
                    cnt_d = '0;
                    if (div_zero || overflow) begin
                        // Park the final answer in the quotient register, unsigned path.
                        state_d   = StFinish;
                        sel_rem_d = 1'b0;
                        neg_res_d = 1'b0;
                        quo_d     = special_val;
                        dvs_d     = b_mag;
                    end else begin
                        state_d   = StCalc;
                        sel_rem_d = op[1];
                        neg_res_d = op[1] ? a_neg : (a_neg ^ b_neg);
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                    end
                end
            end
            StCalc: begin
                rem_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                result_d = fin_val;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= 1'b1;
            sel_rem_q <= 1'b0;
            neg_res_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            sel_rem_q <= sel_rem_d;
            neg_res_q <= neg_res_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_div_unit;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    div_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t scb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics straight from the ISA rules, using native arithmetic.
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        sa  = a;
        sbv = b;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
        case (o)
            2'd0:    return sa / sbv;
            2'd1:    return a / b;
            2'd2:    return sa % sbv;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (done && busy) begin
                checks++;
                errors++;
                $display("FAIL done_with_busy: got done=1 busy=1 expected busy=0");
            end
            if (done) begin
                if (scb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = scb.pop_front();
                    check("result", result, e.res);
                    check("latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int width, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.res    = exp;
        e.due    = cyc + 1 + ref_latency(o, a, b);
        scb.push_back(e);
        for (int i = 0; i < width; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_after_launch", {31'h0, busy}, 32'h1);
            op       = 2'($urandom);
            dividend = $urandom;
            divisor  = $urandom;
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (scb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
            scb.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        op       = 2'd0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_result", result, 32'h0);

        // start held high across reset release must not launch
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("held_start_busy", {31'h0, busy}, 32'h0);
        start = 1'b0;

        do_op(2'd1, 32'd100, 32'd7, 1, 32'd14);
        wait_idle();
        do_op(2'd3, 32'd100, 32'd7, 1, 32'd2);
        wait_idle();
        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD);
        wait_idle();
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF);
        wait_idle();
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1, 32'd1);
        wait_idle();
        do_op(2'd1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        wait_idle();
        do_op(2'd3, 32'd5, 32'd0, 1, 32'd5);
        wait_idle();
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        wait_idle();
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
        wait_idle();

        // Long start pulse, then a fresh edge while busy that must be dropped
        do_op(2'd1, 32'd1234, 32'd10, 5, 32'd123);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_during_ignored_edge", {31'h0, busy}, 32'h1);
        wait_idle();
        repeat (40) @(negedge clk);

        // Reset partway through DIVU 1000 / 3
        @(negedge clk);
        op       = 2'd1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_done", {31'h0, done}, 32'h0);
        check("midreset_result", result, 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        do_op(2'd1, 32'd9, 32'd3, 1, 32'd3);
        wait_idle();

        for (int k = 0; k < 300; k++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 2'($urandom);
            a = pick();
            b = pick();
            do_op(o, a, b, $urandom_range(1, 3), ref_model(o, a, b));
            wait_idle();
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 integer divider implementing RISC-V M-extension DIV, DIVU, REM and REMU semantics. It sits beside the ALU in the execute stage, downstream of whatever raises `start`: the control FSM in the core, or a bench stimulus task holding `start` high for N clocks. A new operation is launched by the rising edge of `start`, so a start pulse of any width launches exactly one division. Results are produced with a one-cycle `done` strobe.

## Interface
- `XLEN`, default 32, operand/result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock; sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; rising-edge sensitive.
- `op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at launch only.
- `dividend`  in  XLEN  rs1 value; sampled at launch only.
- `divisor`  in  XLEN  rs2 value; sampled at launch only.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle strobe; `result` is valid from this cycle on.
- `result`  out  XLEN  quotient or remainder; holds until the next `done`.

## Operation
- Edge detect: register `start_q` captures `start` every cycle; launch = `start & ~start_q & (state == IDLE)`. `start_q` resets to 1, so a `start` held high through reset does not launch; it must drop and rise again.
- States:
  - IDLE: waits for launch.
  - CALC: iterates the division.
  - FINISH: one-cycle output stage.
- IDLE → CALC at launch:
  - Latch `op`, the sign flags and the operand magnitudes. Magnitude is the two's-complement absolute value for DIV/REM and the raw value for DIVU/REMU.
  - Clear the remainder register and the iteration counter.
- IDLE → FINISH directly at launch, skipping CALC, for the special cases:
  - Divisor == 0: DIV/DIVU result = all ones; REM/REMU result = dividend.
  - Signed overflow, i.e. DIV/REM with dividend = 1 followed by XLEN-1 zeros and divisor = all ones: DIV result = dividend; REM result = 0.
- CALC, restoring step, one quotient bit per cycle, MSB first:
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude from the remainder using an XLEN+1-bit subtract.
  - If the trial result is non-negative, keep it and set quotient LSB = 1; otherwise set quotient LSB = 0.
  - After XLEN iterations, go to FINISH.
- FINISH:
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - Register `result`, pulse `done`, return to IDLE.
- A `start` edge while not in IDLE is ignored: no queueing, and it is not remembered.
- `dividend`, `divisor` and `op` may change freely after launch without effect.

## Timing
- Reset values: `busy` = 0, `done` = 0, `result` = 0, state = IDLE, `start_q` = 1.
- Let P0 be the posedge at which launch is sampled. `busy` = 1 from after P0.
- Normal path:
  - CALC occupies posedges P1..P_XLEN; FINISH occupies P_XLEN+1.
  - `result` and `done` = 1 are visible after posedge P_XLEN+1; at the same time `busy` = 0.
  - Latency is XLEN+1 cycles after the start edge is sampled (33 at XLEN = 32).
- Special-case path: FINISH occupies P1; `done` and `result` are visible after P1, a latency of 1.
- `done` is high for exactly one cycle and is never asserted together with `busy`.
- A new launch is possible at the posedge immediately after `done` rises, provided `start` shows a fresh 0→1 transition.
- Reset asserted mid-operation:
  - At the next posedge: IDLE, `busy` = 0, `done` = 0, `result` = 0.
  - The aborted operation never produces `done`.

## Test plan
- DIVU 100 / 7, `start` pulsed for 1 cycle → `done` 33 cycles after launch, `result` = 14; REMU on the same operands → 2.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3); REM -7 % 2 → 0xFFFFFFFF (-1); REM 7 % -2 → 1.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. All four show `done` 1 cycle after launch.
- `start` held high for 5 cycles, then low → exactly one `done`; a second 0→1 `start` edge issued during `busy` → ignored, and no second `done` follows.
- `start` high across reset deassertion, then held high → no launch; after `start` drops and rises again → launch occurs.
- Reset asserted 10 cycles into DIVU 1000 / 3 → `busy` = 0 and `result` = 0 after the next posedge, with no `done`; a following DIVU 9 / 3 → 3.
